// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz round controller.
//   state_t   : 3-bit game state; the numeric value is exported on the fsm output
//   KEY_*     : USB HID keycodes the controller reacts to
package quiz_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StAsk     = 3'd1,
      StCorrect = 3'd2,
      StWrong   = 3'd3,
      StTimeout = 3'd4,
      StOver    = 3'd5,
      StPaused  = 3'd6
   } state_t;

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_B     = 8'h05;
   localparam logic [7:0] KEY_C     = 8'h06;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_P     = 8'h13;

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// SoC-facing signal bundle of the quiz round controller.
//   keycode      : USB HID keycode from the SoC, 0 = no key
//   correct_ans  : correct option of the current question (0=A..3=D)
//   fsm          : current state encoding
//   timer_mins   : remaining minutes
//   timer_secs   : remaining seconds
//   q_index      : current question, 0-based
//   score        : correct answers this game
//   last_correct : result of the most recent answer
//   q_start      : one-cycle pulse, software loads the next question
// Modports: master = SoC side, slave = controller side.
interface quiz_round_ctrl_if;

   logic [7:0] keycode;
   logic [1:0] correct_ans;
   logic [2:0] fsm;
   logic [5:0] timer_mins;
   logic [5:0] timer_secs;
   logic [3:0] q_index;
   logic [3:0] score;
   logic       last_correct;
   logic       q_start;

   modport master (
      output keycode, correct_ans,
      input  fsm, timer_mins, timer_secs, q_index, score, last_correct, q_start
   );

   modport slave (
      input  keycode, correct_ans,
      output fsm, timer_mins, timer_secs, q_index, score, last_correct, q_start
   );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (takes priority over en)
//   en         : count enable; when low the count is frozen
//   tick       : one-cycle pulse every CLK_HZ enabled cycles
module sec_tick_gen #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

   logic [CntW-1:0] cnt_q;

   assign tick = en && (cnt_q == CntMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz game sequencer: decodes keycodes, runs the per-question countdown and
// steps through ask / reveal / game-over phases while keeping score.
//   clk_clk       : system clock
//   reset_reset_n : asynchronous active-low reset
//   soc           : quiz_round_ctrl_if.slave bundle (keycode, correct_ans in;
//                   fsm, timer, q_index, score, last_correct, q_start out)
// Optional feature macro: QUIZ_PAUSE_EN adds the PAUSED state entered/left with P.
module quiz_round_ctrl
   import quiz_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned ROUND_MINS    = 0,
   parameter int unsigned ROUND_SECS    = 30,
   parameter int unsigned REVEAL_SECS   = 3,
   parameter int unsigned NUM_QUESTIONS = 10
) (
   input logic         clk_clk,
   input logic         reset_reset_n,
   quiz_round_ctrl_if.slave soc
);

   localparam logic [5:0] RoundMins  = 6'(ROUND_MINS);
   localparam logic [5:0] RoundSecs  = 6'(ROUND_SECS);
   localparam logic [5:0] RevealSecs = 6'(REVEAL_SECS);
   localparam logic [3:0] LastQ      = 4'(NUM_QUESTIONS - 1);

   state_t     state_q, state_d;
   logic [7:0] key_q;
   logic       evt_q;
   logic [5:0] mins_q, mins_d;
   logic [5:0] secs_q, secs_d;
   logic [3:0] q_index_q, q_index_d;
   logic [3:0] score_q, score_d;
   logic       last_q, last_d;
   logic       q_start_q, q_start_d;
   logic       tick, tick_clr, tick_en;

   logic evt_enter, evt_esc, evt_ans, timer_last;
   logic evt_p;

   // The event is registered so the state reacts one edge after the key is sampled.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         key_q <= 8'h00;
         evt_q <= 1'b0;
      end else begin
         key_q <= soc.keycode;
         evt_q <= (soc.keycode != 8'h00) && (soc.keycode != key_q);
      end
   end

   assign evt_enter  = evt_q && (key_q == KEY_ENTER);
   assign evt_esc    = evt_q && (key_q == KEY_ESC);
   assign evt_ans    = evt_q && (key_q >= KEY_A) && (key_q <= KEY_D);
   assign evt_p      = evt_q && (key_q == KEY_P);
   assign timer_last = (mins_q == 6'd0) && (secs_q == 6'd1);

   always_comb begin
      state_d   = state_q;
      mins_d    = mins_q;
      secs_d    = secs_q;
      q_index_d = q_index_q;
      score_d   = score_q;
      last_d    = last_q;
      q_start_d = 1'b0;

      if (evt_esc) begin
         state_d = StIdle;
         mins_d  = RoundMins;
         secs_d  = RoundSecs;
      end else begin
         case (state_q)
            StIdle: begin
               if (evt_enter) begin
                  state_d   = StAsk;
                  score_d   = 4'd0;
                  q_index_d = 4'd0;
                  last_d    = 1'b0;
                  mins_d    = RoundMins;
                  secs_d    = RoundSecs;
                  q_start_d = 1'b1;
               end
            end
            StAsk: begin
               if (evt_ans) begin
                  mins_d = 6'd0;
                  secs_d = RevealSecs;
                  // A..D are 0x04..0x07, so the low two bits are the option index.
                  if (key_q[1:0] == soc.correct_ans) begin
                     state_d = StCorrect;
                     score_d = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
                     last_d  = 1'b1;
                  end else begin
                     state_d = StWrong;
                     last_d  = 1'b0;
                  end
`ifdef QUIZ_PAUSE_EN
               end else if (evt_p) begin
                  state_d = StPaused;
`endif
               end else if (tick) begin
                  if (timer_last) begin
                     state_d = StTimeout;
                     mins_d  = 6'd0;
                     secs_d  = 6'd0;
                     last_d  = 1'b0;
                  end else if (secs_q == 6'd0) begin
                     mins_d = mins_q - 6'd1;
                     secs_d = 6'd59;
                  end else begin
                     secs_d = secs_q - 6'd1;
                  end
               end
            end
            StCorrect, StWrong, StTimeout: begin
               // Timeout arrives showing 00:00; the reveal time is loaded one cycle later.
               if ((state_q == StTimeout) && (mins_q == 6'd0) && (secs_q == 6'd0)) begin
                  secs_d = RevealSecs;
               end else if (tick) begin
                  if (timer_last) begin
                     if (q_index_q == LastQ) begin
                        state_d = StOver;
                        mins_d  = 6'd0;
                        secs_d  = 6'd0;
                     end else begin
                        state_d   = StAsk;
                        q_index_d = q_index_q + 4'd1;
                        mins_d    = RoundMins;
                        secs_d    = RoundSecs;
                        q_start_d = 1'b1;
                     end
                  end else if (secs_q == 6'd0) begin
                     mins_d = mins_q - 6'd1;
                     secs_d = 6'd59;
                  end else begin
                     secs_d = secs_q - 6'd1;
                  end
               end
            end
            StOver: begin
               mins_d = 6'd0;
               secs_d = 6'd0;
               if (evt_enter) begin
                  state_d = StIdle;
                  mins_d  = RoundMins;
                  secs_d  = RoundSecs;
               end
            end
`ifdef QUIZ_PAUSE_EN
            StPaused: begin
               if (evt_p) begin
                  state_d = StAsk;
               end
            end
`endif
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

`ifdef QUIZ_PAUSE_EN
   // Pausing and resuming keep the partial second; every other state entry restarts it.
   assign tick_clr = (state_d != state_q) && (state_q != StPaused) && (state_d != StPaused);
   assign tick_en  = (state_q != StPaused);
`else
   assign tick_clr = (state_d != state_q);
   assign tick_en  = 1'b1;
`endif

   sec_tick_gen #(
      .CLK_HZ(CLK_HZ)
   ) u_tick (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .clr   (tick_clr),
      .en    (tick_en),
      .tick  (tick)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= StIdle;
         mins_q    <= RoundMins;
         secs_q    <= RoundSecs;
         q_index_q <= 4'd0;
         score_q   <= 4'd0;
         last_q    <= 1'b0;
         q_start_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mins_q    <= mins_d;
         secs_q    <= secs_d;
         q_index_q <= q_index_d;
         score_q   <= score_d;
         last_q    <= last_d;
         q_start_q <= q_start_d;
      end
   end

   assign soc.fsm          = state_q;
   assign soc.timer_mins   = mins_q;
   assign soc.timer_secs   = secs_q;
   assign soc.q_index      = q_index_q;
   assign soc.score        = score_q;
   assign soc.last_correct = last_q;
   assign soc.q_start      = q_start_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Self-checking bench for quiz_round_ctrl (CLK_HZ=10, round 0:03, reveal 2 s, 2 questions).
// Expected output snapshots are queued with the cycle they are due and compared at
// the falling edge of that cycle.
module tb_quiz_round_ctrl;

   localparam logic [7:0] K_ENTER = 8'h28;
   localparam logic [7:0] K_ESC   = 8'h29;
   localparam logic [7:0] K_A     = 8'h04;
   localparam logic [7:0] K_B     = 8'h05;
   localparam logic [7:0] K_C     = 8'h06;
   localparam logic [7:0] K_P     = 8'h13;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_errors;

   quiz_round_ctrl_if bus ();

   quiz_round_ctrl #(
      .CLK_HZ        (10),
      .ROUND_MINS    (0),
      .ROUND_SECS    (3),
      .REVEAL_SECS   (2),
      .NUM_QUESTIONS (2)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .soc           (bus)
   );

   typedef struct {
      string tag;
      int    due;
      int    f, m, s, qi, sc, lc, qs;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic cmp_field(input string tag, input string fld, input int got, input int want);
      if (want >= 0) check({tag, ".", fld}, got, want);
   endtask

   task automatic compare(input exp_t e);
      cmp_field(e.tag, "fsm",     int'(bus.fsm),          e.f);
      cmp_field(e.tag, "mins",    int'(bus.timer_mins),   e.m);
      cmp_field(e.tag, "secs",    int'(bus.timer_secs),   e.s);
      cmp_field(e.tag, "q_index", int'(bus.q_index),      e.qi);
      cmp_field(e.tag, "score",   int'(bus.score),        e.sc);
      cmp_field(e.tag, "last",    int'(bus.last_correct), e.lc);
      cmp_field(e.tag, "q_start", int'(bus.q_start),      e.qs);
   endtask

   // -1 in any field means "don't care".
   task automatic expect_at(input string tag, input int k, input int f, input int m,
                            input int s, input int qi, input int sc, input int lc,
                            input int qs);
      exp_t e;
      e.tag = tag; e.due = cyc + k;
      e.f = f; e.m = m; e.s = s; e.qi = qi; e.sc = sc; e.lc = lc; e.qs = qs;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            compare(sb[i]);
            sb.delete(i);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [7:0] k);
      bus.keycode = k;
      @(negedge clk);
      bus.keycode = 8'h00;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wrong_cnt;
      int prev_fsm;
      int bad;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.keycode = 8'h00;
      bus.correct_ans = 2'd0;
      wait_cyc(3);
      rst_n = 1'b1;
      expect_at("reset", 1, 0, 0, 3, 0, 0, 0, 0);
      wait_cyc(2);

      // Start the game.
      expect_at("enter", 2, 1, 0, 3, 0, 0, 0, 1);
      expect_at("qs_off", 3, 1, -1, -1, -1, -1, -1, 0);
      press(K_ENTER);

      // Question 0 answered correctly.
      bus.correct_ans = 2'd2;
      expect_at("correct", 2, 2, 0, 2, 0, 1, 1, 0);
      expect_at("reveal_end-1", 21, 2, 0, 1, 0, 1, 1, 0);
      expect_at("next_q", 22, 1, 0, 3, 1, 1, 1, 1);
      press(K_C);
      wait_cyc(20);

      // Question 1 runs out; it is the last question.
      expect_at("tick1", 10, 1, 0, 2, 1, 1, 1, 0);
      expect_at("tick2", 20, 1, 0, 1, 1, 1, 1, 0);
      expect_at("pre_timeout", 29, 1, 0, 1, 1, 1, 1, 0);
      expect_at("timeout", 30, 4, 0, 0, 1, 1, 0, 0);
      expect_at("to_reveal", 31, 4, 0, 2, 1, 1, 0, 0);
      expect_at("pre_over", 49, 4, 0, 1, 1, 1, 0, 0);
      expect_at("over", 50, 5, 0, 0, 1, 1, 0, 0);
      expect_at("over_held", 60, 5, 0, 0, 1, 1, 0, 0);
      wait_cyc(60);

      expect_at("over_to_idle", 2, 0, 0, 3, -1, 1, -1, 0);
      press(K_ENTER);
      expect_at("restart", 2, 1, 0, 3, 0, 0, 0, 1);
      press(K_ENTER);

      // Held A (wrong) fires once; then B lands with the 00:01 tick.
      bus.correct_ans = 2'd1;
      expect_at("wrong", 2, 3, 0, 2, 0, 0, 0, 0);
      expect_at("held_next_q", 22, 1, 0, 3, 1, 0, 0, 1);
      expect_at("held_end", 50, 1, 0, 1, 1, 0, 0, 0);
      bus.keycode = K_A;
      wrong_cnt = 0;
      prev_fsm = int'(bus.fsm);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (int'(bus.fsm) == 3 && prev_fsm != 3) wrong_cnt++;
         prev_fsm = int'(bus.fsm);
      end
      check("held_key_once", wrong_cnt, 1);
      expect_at("ans_beats_tick", 2, 2, 0, 2, 1, 1, 1, 0);
      press(K_B);

      expect_at("esc", 2, 0, 0, 3, -1, -1, -1, 0);
      press(K_ESC);

      // Score one point, then reset mid-game.
      expect_at("enter2", 2, 1, 0, 3, 0, 0, 0, 1);
      press(K_ENTER);
      bus.correct_ans = 2'd0;
      expect_at("correct_a", 2, 2, 0, 2, 0, 1, 1, 0);
      press(K_A);
      wait_cyc(3);
      rst_n = 1'b0;
      expect_at("mid_reset", 1, 0, 0, 3, 0, 0, 0, 0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(1);

      expect_at("enter3", 2, 1, 0, 3, 0, 0, 0, 1);
      press(K_ENTER);
`ifdef QUIZ_PAUSE_EN
      wait_cyc(13);
      expect_at("paused", 2, 6, 0, 2, 0, 0, 0, 0);
      press(K_P);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (int'(bus.fsm) != 6 || int'(bus.timer_secs) != 2) bad++;
      end
      check("pause_frozen", bad, 0);
      expect_at("resumed", 2, 1, 0, 2, 0, 0, 0, 0);
      expect_at("resume_pre_tick", 6, 1, 0, 2, 0, 0, 0, 0);
      expect_at("resume_tick", 7, 1, 0, 1, 0, 0, 0, 0);
      press(K_P);
      wait_cyc(8);
`else
      wait_cyc(5);
      expect_at("p_ignored", 2, 1, 0, 3, 0, 0, 0, 0);
      expect_at("p_tick", 5, 1, 0, 2, 0, 0, 0, 0);
      bad = 0;
      bus.keycode = K_P;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (int'(bus.fsm) == 6) bad++;
      end
      bus.keycode = 8'h00;
      check("no_pause_state", bad, 0);
      wait_cyc(1);
      expect_at("unlisted_key", 2, 1, -1, -1, 0, 0, 0, 0);
      press(8'h10);
`endif

      wait_cyc(5);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Game sequencer for the quiz arcade. It decodes USB keyboard keycodes from the SoC, runs the per-question countdown, and moves through ask, reveal and game-over phases. It keeps score and question index, and drives the `fsm`, `timer_mins` and `timer_secs` inputs of the SoC so software can render state and remaining time. It sits in the top level between the SoC keycode export and the SoC state/timer imports.

## Interface
- CLK_HZ, 50_000_000, clock frequency; sets the 1 s tick period
- ROUND_MINS, 0, question time, minutes (0..63)
- ROUND_SECS, 30, question time, seconds (0..59)
- REVEAL_SECS, 3, result display time, seconds (1..59)
- NUM_QUESTIONS, 10, questions per game (1..15)
- clk_clk  in  1  system clock
- reset_reset_n  in  1  reset; asynchronous, active-low
- keycode  in  8  USB HID keycode from SoC; 0 = no key
- correct_ans  in  2  correct option for current question (0=A..3=D), written by software
- fsm  out  3  current state encoding
- timer_mins  out  6  remaining minutes
- timer_secs  out  6  remaining seconds
- q_index  out  4  current question, 0-based
- score  out  4  correct answers this game
- last_correct  out  1  result of the most recent answer
- q_start  out  1  one-cycle pulse; software loads the next question

## Operation
- Key event: `key_q` holds the registered `keycode`. An event fires when `keycode != 0 && keycode != key_q`. Held keys fire once.
- Keys: Enter=0x28, Esc=0x29, A..D=0x04..0x07, P=0x13.
- States (fsm value):
  - IDLE=0
  - ASK=1
  - CORRECT=2
  - WRONG=3
  - TIMEOUT=4
  - OVER=5
  - PAUSED=6 (macro only)
- IDLE
  - Enter → ASK.
  - Clears score, q_index and last_correct.
  - Loads timer with ROUND_MINS:ROUND_SECS.
  - Pulses q_start.
- ASK
  - Each tick decrements the timer; when secs=0, mins decrements and secs becomes 59.
  - A tick at 00:01 writes 00:00 and moves to TIMEOUT on the same edge.
  - An A..D event compares its option index against `correct_ans` sampled that cycle:
    - Equal → CORRECT; score+1, saturating at 15; last_correct=1.
    - Not equal → WRONG; last_correct=0.
- Entry to CORRECT, WRONG or TIMEOUT loads timer 00:REVEAL_SECS. TIMEOUT sets last_correct=0.
- CORRECT/WRONG/TIMEOUT count down by ticks. On the tick reaching 00:00:
  - If q_index == NUM_QUESTIONS-1 → OVER.
  - Otherwise q_index+1, timer reloaded with the round time, q_start pulses, → ASK.
- OVER: timer shows 00:00; score is held. Enter → IDLE, timer reloaded with the round time.
- Esc in any state → IDLE, timer reloaded with the round time. Esc takes priority over every other event.
- Tick divider clears on every state entry, so each phase starts with a full second.
- Non-listed keycodes are ignored.

## Timing
- Reset values:
  - fsm=0
  - timer = ROUND_MINS:ROUND_SECS
  - q_index=0, score=0, last_correct=0, q_start=0
  - key_q=0, divider=0
- All outputs are registered.
- Key-to-state latency: the keycode change is sampled at edge N; `fsm` updates at edge N+1.
- q_start is high for exactly the cycle after the transition into ASK.
- Tick fires every CLK_HZ cycles. The first tick after state entry comes CLK_HZ cycles after entry.
- Answer event and tick in the same cycle: the answer wins and the timer is not decremented.
- Answer event and the 00:01 tick in the same cycle: CORRECT/WRONG, not TIMEOUT.
- Reset mid-game aborts immediately to the reset values.

## Configuration
- QUIZ_PAUSE_EN
  - Defined: a P event in ASK → PAUSED. The divider and timer are frozen and answers are ignored. A P event → ASK, resuming the divider count unchanged, so the entry-clear rule does not apply. Esc → IDLE.
  - Undefined: P is ignored and value 6 is never produced.

## Structure
- Package `quiz_pkg`: state enum (3-bit, values as above) and keycode localparams (KEY_ENTER, KEY_ESC, KEY_A..KEY_D, KEY_P).
- Sub-module `sec_tick_gen`:
  - Parameter CLK_HZ; inputs clr and en; output one-cycle tick.
  - Counter is $clog2(CLK_HZ) bits.
- Timer is a separate mins/secs register pair with a borrow from secs to mins.

## Test plan
Use CLK_HZ=10, ROUND 0:03, REVEAL_SECS=2, NUM_QUESTIONS=2.
- Reset, then Enter (0x28) → fsm=1 two cycles later; q_start pulses once; timer 0:03; score=0.
- In ASK with correct_ans=2, press C (0x06) → fsm=2, score=1, last_correct=1. After 20 cycles → fsm=1, q_index=1, q_start pulse.
- In ASK, no key → timer 0:02, 0:01, then fsm=4 with timer 0:00 at cycle 30. After the reveal on the last question → fsm=5.
- Hold A for 50 cycles with correct_ans=1 → exactly one WRONG (fsm=3); score unchanged.
- Press B on the same cycle as the 0:01→0:00 tick with correct_ans=1 → fsm=2, not 4; Esc from fsm=2 → fsm=0, timer 0:03.
- With QUIZ_PAUSE_EN: P at 0:02 + 5 cycles → fsm=6 held for 100 cycles; P → fsm=1; next tick 5 cycles later gives 0:01.
